// File: rtl/i2c_pkg.sv
// Shared I2C definitions: slave FSM state encoding, memory geometry
// and the bus frequency constants also used by the I2C master.
package i2c_pkg;

    localparam int MEM_DEPTH = 128;
    localparam int ADDR_W    = 7;

    localparam int freqSystem = 50_000_000;
    localparam int freqI2C    = 100_000;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } slave_state_t;

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: synchronizes scl/sda, keeps one history stage and
// decodes one-cycle scl_rise/scl_fall/start/stop pulses.
// Ports: clk, rst (async, active high), scl, sda (raw pins) ->
//        sda_s (synchronized sda), scl_rise, scl_fall, start, stop.
module i2c_bus_monitor
    import i2c_pkg::*;
#(
    parameter int syncStages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [syncStages-1:0] scl_sync;
    logic [syncStages-1:0] sda_sync;
    logic                  scl_s;
    logic                  scl_h;
    logic                  sda_h;

    // Reset to the idle bus level so no false START/STOP follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_h    <= 1'b1;
            sda_h    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[syncStages-2:0], scl};
            sda_sync <= {sda_sync[syncStages-2:0], sda};
            scl_h    <= scl_s;
            sda_h    <= sda_s;
        end
    end

    assign scl_s = scl_sync[syncStages-1];
    assign sda_s = sda_sync[syncStages-1];

    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start    = scl_s & scl_h & ~sda_s & sda_h;
    assign stop     = scl_s & scl_h & sda_s & ~sda_h;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave with a 128-byte register memory addressed by the 7-bit
// bus address; the R/W bit selects store or fetch of one byte.
// Ports: clk, rst (async, active high), scl, sda (open drain inout),
//        busy, done, ackErr, memWr, memAddr[6:0], memWdata[7:0].
// Macro I2C_SLAVE_BURST_EN enables multi-byte bursts with pointer
// auto-increment; without it only one data byte per transaction.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int          syncStages = 2,
    parameter logic [7:0]  memInit    = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              busy,
    output logic              done,
    output logic              ackErr,
    output logic              memWr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [7:0]        memWdata
);

`ifdef I2C_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    slave_state_t      state;
    slave_state_t      state_nxt;
    logic [7:0]        mem [MEM_DEPTH];
    logic [7:0]        sh;
    logic [3:0]        cnt;
    logic              rw;
    logic              sda_low;
    logic              drive_nxt;
    logic              got_byte;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              sda_s;
    logic              scl_rise;
    logic              scl_fall;
    logic              start;
    logic              stop;

    i2c_bus_monitor #(.syncStages(syncStages)) u_mon (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    // The drive register is async-reset, so reset releases sda at once.
    assign sda = sda_low ? 1'b0 : 1'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // In the ack states cnt != 0 means the 9th scl rise has been seen.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR:
                    if (scl_rise && cnt == 4'd7) state_nxt = ADDR_ACK;
                ADDR_ACK:
                    if (scl_fall && cnt != 4'd0)
                        state_nxt = rw ? RD_DATA : WR_DATA;
                WR_DATA:
                    if (scl_rise && cnt == 4'd7) state_nxt = WR_ACK;
                WR_ACK:
                    if (scl_fall && cnt != 4'd0)
                        state_nxt = BURST ? WR_DATA : WAIT_STOP;
                RD_DATA:
                    if (scl_fall && cnt == 4'd8) state_nxt = RD_ACK;
                RD_ACK:
                    if (scl_rise)
                        state_nxt = (BURST && !sda_s) ? RD_DATA : WAIT_STOP;
                default: ;
            endcase
        end
    end

    // Outputs and next sda drive; sda only changes on scl falls.
    always_comb begin
        busy      = (state != IDLE);
        rd_addr   = (state == RD_ACK) ? memAddr + 7'd1 : memAddr;
        rd_data   = mem[rd_addr];
        drive_nxt = sda_low;
        if (start || stop) begin
            drive_nxt = 1'b0;
        end else if (scl_fall) begin
            case (state)
                ADDR_ACK:
                    drive_nxt = (cnt == 4'd0) ? 1'b1 : (rw & ~rd_data[7]);
                WR_ACK:
                    drive_nxt = (cnt == 4'd0);
                RD_DATA:
                    drive_nxt = (cnt == 4'd8) ? 1'b0 : ~sh[7];
                default:
                    drive_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= memInit;
            sh       <= '0;
            cnt      <= '0;
            rw       <= 1'b0;
            sda_low  <= 1'b0;
            got_byte <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            memWr    <= 1'b0;
            done     <= 1'b0;
            ackErr   <= 1'b0;
        end else begin
            sda_low <= drive_nxt;
            memWr   <= 1'b0;
            done    <= stop & got_byte;
            if (stop) begin
                cnt      <= '0;
                got_byte <= 1'b0;
            end else if (start) begin
                cnt    <= '0;
                ackErr <= 1'b0;
            end else begin
                case (state)
                    ADDR:
                        if (scl_rise) begin
                            sh <= {sh[6:0], sda_s};
                            if (cnt == 4'd7) begin
                                memAddr <= sh[6:0];
                                rw      <= sda_s;
                                cnt     <= '0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    ADDR_ACK:
                        if (scl_rise) begin
                            cnt <= 4'd1;
                        end else if (scl_fall && cnt != 4'd0) begin
                            cnt <= '0;
                            // MSB goes out now; keep the rest queued.
                            if (rw) sh <= {rd_data[6:0], 1'b0};
                        end
                    WR_DATA:
                        if (scl_rise) begin
                            sh <= {sh[6:0], sda_s};
                            if (cnt == 4'd7) begin
                                mem[memAddr] <= {sh[6:0], sda_s};
                                memWdata     <= {sh[6:0], sda_s};
                                memWr        <= 1'b1;
                                got_byte     <= 1'b1;
                                cnt          <= '0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end
                    WR_ACK:
                        if (scl_rise) begin
                            cnt <= 4'd1;
                        end else if (scl_fall && cnt != 4'd0) begin
                            cnt <= '0;
                            if (BURST) memAddr <= memAddr + 7'd1;
                        end
                    RD_DATA:
                        if (scl_rise) begin
                            cnt <= cnt + 4'd1;
                            // Released bit seen low: master is fighting us.
                            if (!sda_low && !sda_s) ackErr <= 1'b1;
                        end else if (scl_fall && cnt != 4'd8) begin
                            sh <= {sh[6:0], 1'b0};
                        end else if (scl_fall) begin
                            cnt      <= '0;
                            got_byte <= 1'b1;
                        end
                    RD_ACK:
                        if (scl_rise && BURST && !sda_s) begin
                            memAddr <= memAddr + 7'd1;
                            sh      <= rd_data;
                        end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged master drives scl/sda
// and every result is compared against hand-computed values.
module tb_i2c_slave;

`ifdef I2C_SLAVE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_low;
    wire        sda;
    logic       busy;
    logic       done;
    logic       ackErr;
    logic       memWr;
    logic [6:0] memAddr;
    logic [7:0] memWdata;

    int         total = 0;
    int         bad = 0;
    int         wr_cnt = 0;
    int         done_cnt = 0;
    int         w0;
    int         d0;
    logic [6:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       watch = 1'b0;
    logic       busy_drop = 1'b0;
    logic [7:0] d;
    logic       a;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_slave dut (
        .clk      (clk),
        .rst      (rst),
        .scl      (scl),
        .sda      (sda),
        .busy     (busy),
        .done     (done),
        .ackErr   (ackErr),
        .memWr    (memWr),
        .memAddr  (memAddr),
        .memWdata (memWdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (memWr) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= memAddr;
            wr_data <= memWdata;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (watch && !busy) busy_drop <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic q_wait;
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start;
        m_low = 1'b0; q_wait;
        scl = 1'b1;   q_wait;
        m_low = 1'b1; q_wait;
        scl = 1'b0;   q_wait;
    endtask

    task automatic bus_stop;
        m_low = 1'b1; q_wait;
        scl = 1'b1;   q_wait;
        m_low = 1'b0; q_wait;
        q_wait;
    endtask

    task automatic put_bit(input logic b);
        m_low = ~b; q_wait;
        scl = 1'b1; q_wait;
        q_wait;
        scl = 1'b0; q_wait;
    endtask

    task automatic get_bit(input logic jam, output logic b);
        m_low = jam; q_wait;
        scl = 1'b1;  q_wait;
        b = sda;     q_wait;
        scl = 1'b0;  q_wait;
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(1'b0, ack);
    endtask

    task automatic get_byte(input logic jam, input logic ack,
                            output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(jam && i == 7, b);
            v[i] = b;
        end
        put_bit(ack);
    endtask

    task automatic rd_txn(input logic [6:0] ad, input logic jam,
                          output logic [7:0] v);
        logic k;
        bus_start;
        put_byte({ad, 1'b1}, k);
        check("rd_addr_ack", k, 0);
        get_byte(jam, 1'b1, v);
        bus_stop;
    endtask

    task automatic wr_txn(input logic [6:0] ad, input logic [7:0] v);
        logic k;
        bus_start;
        put_byte({ad, 1'b0}, k);
        check("wr_addr_ack", k, 0);
        put_byte(v, k);
        check("wr_data_ack", k, 0);
        bus_stop;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; scl = 1'b1; m_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ackerr", ackErr, 0);
        check("rst_memwr", memWr, 0);
        check("rst_addr", memAddr, 0);
        check("rst_wdata", memWdata, 0);
        check("rst_sda", sda, 1);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        rd_txn(7'h7F, 1'b0, d);
        check("rd_init_7f", d, 8'h00);
        check("rd_init_ackerr", ackErr, 0);

        w0 = wr_cnt; d0 = done_cnt;
        wr_txn(7'h12, 8'hA5);
        check("wr_count", wr_cnt - w0, 1);
        check("wr_addr", wr_addr, 7'h12);
        check("wr_data", wr_data, 8'hA5);
        rd_txn(7'h12, 1'b0, d);
        check("rd_12", d, 8'hA5);
        check("done_count", done_cnt - d0, 2);

        w0 = wr_cnt;
        bus_start;
        check("busy_mid", busy, 1);
        put_byte({7'h12, 1'b0}, a);
        check("abort_addr_ack", a, 0);
        put_bit(1'b0); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
        bus_stop;
        check("abort_no_wr", wr_cnt - w0, 0);
        check("abort_busy", busy, 0);
        rd_txn(7'h12, 1'b0, d);
        check("abort_rd_12", d, 8'hA5);

        bus_start;
        watch = 1'b1;
        put_byte({7'h05, 1'b0}, a);
        check("sr_waddr_ack", a, 0);
        put_byte(8'h5A, a);
        check("sr_wdata_ack", a, 0);
        bus_start;
        put_byte({7'h05, 1'b1}, a);
        check("sr_raddr_ack", a, 0);
        get_byte(1'b0, 1'b1, d);
        watch = 1'b0;
        bus_stop;
        check("sr_rd_05", d, 8'h5A);
        check("sr_wr_addr", wr_addr, 7'h05);
        check("sr_busy_drop", busy_drop, 0);

        bus_start;
        put_byte({7'h7F, 1'b0}, a);
        check("bst_addr_ack", a, 0);
        put_byte(8'h11, a);
        check("bst_ack1", a, 0);
        put_byte(8'h22, a);
        check("bst_ack2", a, BURST ? 0 : 1);
        bus_stop;
        rd_txn(7'h7F, 1'b0, d);
        check("bst_rd_7f", d, 8'h11);
        rd_txn(7'h00, 1'b0, d);
        check("bst_rd_00", d, BURST ? 8'h22 : 8'h00);

        rd_txn(7'h12, 1'b1, d);
        check("jam_ackerr", ackErr, 1);
        rd_txn(7'h05, 1'b0, d);
        check("jam_rd_05", d, 8'h5A);
        check("jam_cleared", ackErr, 0);

        bus_start;
        put_byte({7'h7F, 1'b1}, a);
        check("mr_addr_ack", a, 0);
        check("mr_sda_low", sda, 0);
        rst = 1'b1;
        #1;
        check("mr_sda_rel", sda, 1);
        check("mr_busy", busy, 0);
        check("mr_addr", memAddr, 0);
        check("mr_wdata", memWdata, 0);
        scl = 1'b1; m_low = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rd_txn(7'h7F, 1'b0, d);
        check("mr_rd_7f", d, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Responder end of the on-chip I2C link: a 7-bit-addressed, 128-byte register memory that sits on the `sda`/`scl` bus opposite the I2C master. The 7 address bits sent by the master after START index the memory directly. The R/W bit selects the operation: store the following byte, or return the stored byte. The block oversamples the bus with the system clock, decodes START/STOP and bits, acknowledges bytes, and drives `sda` open-drain only.

## Interface
- `syncStages`, 2, flip-flop stages on the `scl`/`sda` inputs (≥2)
- `memInit`, 8'h00, reset value of every memory byte
- `clk`  input  1  system clock (≥16× `scl` rate; 50 MHz nominal vs 100 kHz bus)
- `rst`  input  1  asynchronous, active-high reset
- `scl`  input  1  bus clock from master (no clock stretching)
- `sda`  inout  1  bus data; block drives only `1'b0` or `1'bz`
- `busy`  output  1  high from detected START to detected STOP
- `done`  output  1  one-`clk` pulse at STOP ending a transaction that completed ≥1 data byte
- `ackErr`  output  1  sticky; set when the master drives `sda` low during a slave-sent bit that should be 1 (bus contention); cleared at next START
- `memWr`  output  1  one-`clk` pulse when a byte is committed to memory
- `memAddr`  output  7  current memory pointer
- `memWdata`  output  8  byte committed on the last `memWr`

## Operation
- Input path: 2-flop synchronizers (`syncStages`) on `scl` and `sda`, then one history register. Edge events come from the synchronized values only.
  - `sclRise` / `sclFall`: edges of the synchronized `scl`.
  - START: `sda` 1→0 while `scl` = 1.
  - STOP: `sda` 0→1 while `scl` = 1.
- Bits are sampled on `sclRise`, MSB first. The slave changes `sda` only on `sclFall`.
- FSM states:
  - IDLE: `sda` released. START → ADDR.
  - ADDR: shift 8 bits. After the 8th: `memAddr` ← bits[7:1], latch R/W → ADDR_ACK.
  - ADDR_ACK: pull `sda` low for the 9th clock. On the following `sclFall`: W → WR_DATA; R → load shift register with `mem[memAddr]` → RD_DATA.
  - WR_DATA: shift 8 bits. After the 8th, write `mem[memAddr]` and pulse `memWr` → WR_ACK.
  - WR_ACK: pull `sda` low for the 9th clock, then go to WR_DATA (burst, see Configuration) or WAIT_STOP.
  - RD_DATA: drive the MSB on entry; drive each following bit on `sclFall` (0 = pull low, 1 = release). After the 8th bit's `sclFall`, release `sda` → RD_ACK.
  - RD_ACK: sample the master's ack on `sclRise`. ACK (0) with burst → increment pointer, reload, RD_DATA. NACK (1) → WAIT_STOP.
  - WAIT_STOP: `sda` released; wait for STOP or START.
- START in any state (repeated start) → ADDR, bit counter cleared, `sda` released.
- STOP in any state → IDLE, `sda` released. A partial byte is discarded and never written.
- Pointer arithmetic is 7-bit modulo: 7'h7F + 1 = 7'h00.
- A write and a read of the same address are never in the same cycle; memory is single-port.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `ackErr`=0, `memWr`=0, `memAddr`=0, `memWdata`=0.
  - `sda` released, FSM IDLE, all memory = `memInit`.
- Event latency: a pin transition is seen as an edge event `syncStages`+1 `clk` cycles later.
- `sda` drive/release takes effect ≤`syncStages`+2 `clk` after the `scl` falling pin edge, well inside the ¼-period hold window.
- `memWr` asserts `syncStages`+1 cycles after the 8th `scl` rising pin edge. `memAddr`/`memWdata` are valid in the same cycle.
- Read data is loaded on the ADDR_ACK→RD_DATA transition, so a write committed earlier in the same transaction is visible.
- Reset mid-transaction: `sda` is released asynchronously, the FSM goes to IDLE, and the memory is reinitialized.

## Configuration
- `I2C_SLAVE_BURST_EN` defined: multi-byte bursts.
  - Write: after WR_ACK return to WR_DATA; the pointer increments after each committed byte.
  - Read: master ACK continues with the next byte.
- Undefined: single byte only.
  - Write: after the first data byte → WAIT_STOP; the slave NACKs (releases `sda`) any further byte.
  - Read: after one byte → WAIT_STOP regardless of the master's ack.

## Structure
- Package `i2c_pkg`:
  - slave state enum `slave_state_t`
  - `MEM_DEPTH`=128
  - `ADDR_W`=7
  - shared bus frequency constants (`freqSystem`, `freqI2C`) already used by the master
- Sub-module `i2c_bus_monitor`: synchronizers, history registers, and `sclRise`/`sclFall`/`start`/`stop` one-cycle pulses. Verified standalone.

## Test plan
- Write then read: master writes 0xA5 to address 0x12, then reads 0x12.
  - Address and data ACKs are low.
  - `memWr` pulses once with `memAddr`=0x12, `memWdata`=0xA5.
  - The read returns 0xA5; `done` pulses twice.
- Read after reset: read address 0x7F → returns 0x00 (`memInit`); `ackErr`=0.
- Abort by STOP: STOP after 4 bits of a write data byte → no `memWr`, `busy`=0, next read of that address returns the old value.
- Repeated start: write address 0x05, then START (no STOP) with a read of 0x05 → FSM restarts in ADDR and returns the stored value; `busy` stays high throughout.
- Burst (`I2C_SLAVE_BURST_EN`): write 0x11, 0x22 starting at 0x7F → `mem[7F]`=0x11, `mem[00]`=0x22 (wrap). Without the macro, the second byte is NACKed and `mem[00]` is unchanged.
- Reset mid-read: assert `rst` while the slave is pulling `sda` low → `sda` is `z` within the same cycle; all outputs return to reset values.
